if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 60 ++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with PC register, IF/ID pipeline register and fetch counter
//   clk, rst            : clock, synchronous active-high reset
//   stall               : hold PC and IF/ID
//   redirect            : load redirect_pc (word-aligned) and squash IF/ID; beats stall
//   redirect_pc         : redirect target byte address
//   imem_rdata          : instruction word from the combinational ROM at imem_addr
//   imem_addr, pc       : current fetch address (register output)
//   if_id_instr/pc4     : latched instruction and its PC+4 (zero when squashed)
//   if_id_valid         : IF/ID holds a real instruction
//   fetch_count         : instructions accepted into IF/ID, wraps
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, pc_plus4;
  logic valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign pc_plus4 = pc_q + 32'd4;
  always_comb begin
    pc_d    = redirect ? {redirect_pc[31:2], 2'b00} : stall ? pc_q : pc_plus4;
    instr_d = redirect ? 32'h0 : stall ? instr_q : imem_rdata;
    pc4_d   = redirect ? 32'h0 : stall ? pc4_q : pc_plus4;
    valid_d = redirect ? 1'b0 : stall ? valid_q : 1'b1;
    cnt_d   = (redirect || stall) ? cnt_q : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign fetch_count = cnt_q;
endmodule
